// File: rtl/nes_pkg.sv
// Shared types, widths and the priority-select helper for the NES button event block.
package nes_pkg;

    localparam int unsigned NES_NUM_BTNS = 8;
    localparam int unsigned NES_EVT_W    = 4;
    localparam int unsigned NES_STAMP_W  = 16;

    typedef enum logic [2:0] {
        BTN_A      = 3'd0,
        BTN_B      = 3'd1,
        BTN_SELECT = 3'd2,
        BTN_START  = 3'd3,
        BTN_UP     = 3'd4,
        BTN_DOWN   = 3'd5,
        BTN_LEFT   = 3'd6,
        BTN_RIGHT  = 3'd7
    } nes_btn_e;

    typedef struct packed {
        logic       pressed;
        logic [2:0] idx;
    } nes_evt_t;

    // Lowest set bit wins; returns BTN_A for an empty mask (caller gates on |mask).
    function automatic nes_btn_e nes_lowest_idx(input logic [NES_NUM_BTNS-1:0] mask);
        nes_btn_e idx;
        idx = BTN_A;
        for (int i = int'(NES_NUM_BTNS) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = nes_btn_e'(3'(i));
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/nes_evt_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Depth must be a power of two so the pointers wrap naturally.
module nes_evt_fifo #(
    parameter int unsigned Width = 4,
    parameter int unsigned Depth = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] level_o
);

    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned LevelW = $clog2(Depth + 1);

    logic [Width-1:0]  mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LevelW-1:0] count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == LevelW'(Depth));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/nes_button_events.sv
// Per-button debounce, press/release event generation and event FIFO for an NES pad.
// Optional NES_EVT_TIMESTAMP_EN adds a sample-frame counter and per-event evt_stamp output.
module nes_button_events
    import nes_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = 3,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                            clk_900KHz,
    input  logic                            reset,
    input  logic                            sample_valid,
    input  logic [NES_NUM_BTNS-1:0]         btn_sample,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic [NES_EVT_W-1:0]            evt_code,
    output logic [NES_NUM_BTNS-1:0]         btn_state,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            overflow
`ifdef NES_EVT_TIMESTAMP_EN
    ,
    output logic [NES_STAMP_W-1:0]          evt_stamp
`endif
);

    localparam int unsigned LevelW = $clog2(FIFO_DEPTH + 1);
    localparam logic [3:0]  CntMax = 4'(DEBOUNCE_CNT - 1);
`ifdef NES_EVT_TIMESTAMP_EN
    localparam int unsigned FifoW  = NES_EVT_W + NES_STAMP_W;
`else
    localparam int unsigned FifoW  = NES_EVT_W;
`endif

    logic [NES_NUM_BTNS-1:0]      btn_state_q, btn_state_d;
    logic [NES_NUM_BTNS-1:0][3:0] cnt_q, cnt_d;
    logic [NES_NUM_BTNS-1:0]      pending_q, pending_d;
    logic                         overflow_q, overflow_d;
    logic [NES_NUM_BTNS-1:0]      flip;

    nes_btn_e                     sel_idx;
    logic                         push;
    logic [NES_NUM_BTNS-1:0]      push_mask;
    logic [NES_NUM_BTNS-1:0]      pend_cleared;
    nes_evt_t                     push_evt;

    logic [FifoW-1:0]             fifo_wdata;
    logic [FifoW-1:0]             fifo_rdata;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [LevelW-1:0]            fifo_count;

    // Debounce: a button flips only after DEBOUNCE_CNT consecutive differing samples.
    always_comb begin
        btn_state_d = btn_state_q;
        cnt_d       = cnt_q;
        flip        = '0;
        if (sample_valid) begin
            for (int i = 0; i < int'(NES_NUM_BTNS); i++) begin
                if (btn_sample[i] == btn_state_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CntMax) begin
                    btn_state_d[i] = ~btn_state_q[i];
                    cnt_d[i]       = '0;
                    flip[i]        = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // Scanner: lowest pending index is pushed when the registered full flag allows.
    always_comb begin
        sel_idx          = nes_lowest_idx(pending_q);
        push             = (|pending_q) && !fifo_full;
        push_mask        = '0;
        push_mask[sel_idx] = push;
        push_evt.pressed = btn_state_q[sel_idx];
        push_evt.idx     = sel_idx;
    end

    // Clear from the push applies first, then the debounce flip toggles on top of it.
    always_comb begin
        pend_cleared = pending_q & ~push_mask;
        pending_d    = pend_cleared ^ flip;
        overflow_d   = overflow_q | (|(pend_cleared & flip));
    end

    always_ff @(posedge clk_900KHz or posedge reset) begin
        if (reset) begin
            btn_state_q <= '0;
            cnt_q       <= '0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            btn_state_q <= btn_state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef NES_EVT_TIMESTAMP_EN
    logic [NES_STAMP_W-1:0] frame_q;

    always_ff @(posedge clk_900KHz or posedge reset) begin
        if (reset) begin
            frame_q <= '0;
        end else if (sample_valid) begin
            frame_q <= frame_q + 1'b1;
        end
    end

    assign fifo_wdata = {frame_q, push_evt};
    assign evt_stamp  = fifo_rdata[FifoW-1:NES_EVT_W];
`else
    assign fifo_wdata = push_evt;
`endif

    nes_evt_fifo #(
        .Width (FifoW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_900KHz),
        .rst_i   (reset),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (evt_ready),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_count)
    );

    assign evt_valid  = !fifo_empty;
    assign evt_code   = fifo_rdata[NES_EVT_W-1:0];
    assign btn_state  = btn_state_q;
    assign fifo_level = fifo_count;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_nes_button_events.sv
// Self-checking bench: directed vector table, hand-written corner sequences, and
// randomized stimulus checked against an event-queue reference model.
module tb_nes_button_events;

    localparam int DEB   = 3;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_valid;
    logic [7:0] btn_sample;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_code;
    logic [7:0] btn_state;
    logic [3:0] fifo_level;
    logic       overflow;
`ifdef NES_EVT_TIMESTAMP_EN
    logic [15:0] evt_stamp;
`endif

    nes_button_events #(
        .DEBOUNCE_CNT (DEB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_900KHz   (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .btn_sample   (btn_sample),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .btn_state    (btn_state),
        .fifo_level   (fifo_level),
        .overflow     (overflow)
`ifdef NES_EVT_TIMESTAMP_EN
        ,
        .evt_stamp    (evt_stamp)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: stable levels, run lengths, pending flags, event queue.
    int          m_run [8];
    logic [7:0]  m_state;
    logic [7:0]  m_pend;
    logic        m_ovf;
    logic [15:0] m_frame;
    logic [19:0] m_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_run[i] = 0;
        m_state = '0;
        m_pend  = '0;
        m_ovf   = 1'b0;
        m_frame = '0;
        m_q.delete();
    endtask

    // One clock edge of the event model, using the inputs present at that edge.
    task automatic model_step();
        bit          do_pop;
        bit          do_push;
        logic [19:0] entry;
        do_pop  = (m_q.size() > 0) && evt_ready;
        do_push = 0;
        entry   = '0;
        if (m_pend != 0 && m_q.size() < DEPTH) begin
            for (int i = 0; i < 8; i++) begin
                if (m_pend[i] && !do_push) begin
                    entry     = {m_frame, m_state[i], 3'(i)};
                    m_pend[i] = 1'b0;
                    do_push   = 1;
                end
            end
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(entry);
        if (sample_valid) begin
            m_frame = m_frame + 16'd1;
            for (int i = 0; i < 8; i++) begin
                if (btn_sample[i] == m_state[i]) begin
                    m_run[i] = 0;
                end else if (m_run[i] + 1 == DEB) begin
                    m_run[i]   = 0;
                    m_state[i] = ~m_state[i];
                    if (m_pend[i]) begin
                        m_pend[i] = 1'b0;
                        m_ovf     = 1'b1;
                    end else begin
                        m_pend[i] = 1'b1;
                    end
                end else begin
                    m_run[i]++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [19:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 20'h0;
        chk("evt_valid", evt_valid, m_q.size() != 0);
        chk("evt_code", evt_code, head[3:0]);
        chk("btn_state", btn_state, m_state);
        chk("fifo_level", fifo_level, m_q.size());
        chk("overflow", overflow, m_ovf);
`ifdef NES_EVT_TIMESTAMP_EN
        chk("evt_stamp", evt_stamp, head[19:4]);
`endif
    endtask

    // Inputs are set before the call; outputs are compared 1ns after the edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        #2;
        reset      = 1'b1;
        btn_sample = 8'hFF;
        #1;
        model_reset();
        chk("async reset evt_valid", evt_valid, 1'b0);
        chk("async reset fifo_level", fifo_level, 4'd0);
        chk("async reset btn_state", btn_state, 8'h00);
        chk("async reset overflow", overflow, 1'b0);
        chk("async reset evt_code", evt_code, 4'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs();
        reset      = 1'b0;
        btn_sample = 8'h00;
    endtask

    typedef struct {
        logic       sv;
        logic [7:0] smp;
        logic       rdy;
        logic [7:0] e_state;
        int         e_level;
        logic [3:0] e_code;
    } vec_t;

    vec_t tbl [23];

    initial begin
        logic [7:0] smp;
        // press of A, glitch on UP, simultaneous SELECT/DOWN/RIGHT, then handshake drain
        tbl[0]  = '{1'b1, 8'h01, 1'b0, 8'h00, 0, 4'h0};
        tbl[1]  = '{1'b1, 8'h01, 1'b0, 8'h00, 0, 4'h0};
        tbl[2]  = '{1'b1, 8'h01, 1'b0, 8'h01, 0, 4'h0};
        tbl[3]  = '{1'b0, 8'h01, 1'b0, 8'h01, 1, 4'h8};
        tbl[4]  = '{1'b0, 8'h01, 1'b0, 8'h01, 1, 4'h8};
        tbl[5]  = '{1'b1, 8'h11, 1'b0, 8'h01, 1, 4'h8};
        tbl[6]  = '{1'b1, 8'h11, 1'b0, 8'h01, 1, 4'h8};
        tbl[7]  = '{1'b1, 8'h01, 1'b0, 8'h01, 1, 4'h8};
        tbl[8]  = '{1'b1, 8'h11, 1'b0, 8'h01, 1, 4'h8};
        tbl[9]  = '{1'b1, 8'h11, 1'b0, 8'h01, 1, 4'h8};
        tbl[10] = '{1'b1, 8'h01, 1'b0, 8'h01, 1, 4'h8};
        tbl[11] = '{1'b1, 8'hA5, 1'b0, 8'h01, 1, 4'h8};
        tbl[12] = '{1'b1, 8'hA5, 1'b0, 8'h01, 1, 4'h8};
        tbl[13] = '{1'b1, 8'hA5, 1'b0, 8'hA5, 1, 4'h8};
        tbl[14] = '{1'b0, 8'hA5, 1'b0, 8'hA5, 2, 4'h8};
        tbl[15] = '{1'b0, 8'hA5, 1'b0, 8'hA5, 3, 4'h8};
        tbl[16] = '{1'b0, 8'hA5, 1'b0, 8'hA5, 4, 4'h8};
        tbl[17] = '{1'b0, 8'hA5, 1'b0, 8'hA5, 4, 4'h8};
        tbl[18] = '{1'b0, 8'hA5, 1'b1, 8'hA5, 3, 4'hA};
        tbl[19] = '{1'b0, 8'hA5, 1'b0, 8'hA5, 3, 4'hA};
        tbl[20] = '{1'b0, 8'hA5, 1'b1, 8'hA5, 2, 4'hD};
        tbl[21] = '{1'b0, 8'hA5, 1'b1, 8'hA5, 1, 4'hF};
        tbl[22] = '{1'b0, 8'hA5, 1'b1, 8'hA5, 0, 4'h0};

        reset        = 1'b1;
        sample_valid = 1'b0;
        btn_sample   = 8'h00;
        evt_ready    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;

        for (int r = 0; r < 23; r++) begin
            sample_valid = tbl[r].sv;
            btn_sample   = tbl[r].smp;
            evt_ready    = tbl[r].rdy;
            cycle();
            chk($sformatf("tbl[%0d] btn_state", r), btn_state, tbl[r].e_state);
            chk($sformatf("tbl[%0d] fifo_level", r), fifo_level, tbl[r].e_level);
            chk($sformatf("tbl[%0d] evt_valid", r), evt_valid, tbl[r].e_level != 0);
            chk($sformatf("tbl[%0d] evt_code", r), evt_code, tbl[r].e_code);
        end

        // Backpressure: ten flips of A with the FIFO blocked; eight fit, the 10th loses a pair.
        evt_ready = 1'b0;
        smp       = 8'hA5;
        for (int f = 0; f < 10; f++) begin
            smp[0] = ~smp[0];
            for (int k = 0; k < DEB; k++) begin
                sample_valid = 1'b1;
                btn_sample   = smp;
                cycle();
            end
        end
        sample_valid = 1'b0;
        cycle();
        cycle();
        chk("saturated fifo_level", fifo_level, 4'd8);
        chk("lost pair overflow", overflow, 1'b1);
        chk("after flips btn_state", btn_state, 8'hA5);
        evt_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("drain[%0d] evt_code", k), evt_code, (k % 2 == 1) ? 4'h8 : 4'h0);
            cycle();
        end
        chk("drained fifo_level", fifo_level, 4'd0);
        chk("drained evt_valid", evt_valid, 1'b0);
        chk("overflow sticky", overflow, 1'b1);

        // Reset mid-operation with queued events and a partly advanced counter.
        evt_ready = 1'b0;
        for (int k = 0; k < DEB; k++) begin
            sample_valid = 1'b1;
            btn_sample   = 8'h1A;
            cycle();
        end
        sample_valid = 1'b0;
        repeat (3) cycle();
        chk("queued before reset", fifo_level, 4'd3);
        sample_valid = 1'b1;
        btn_sample   = 8'h00;
        cycle();
        do_reset();

        // Buttons held across reset release come out as press events.
        for (int k = 0; k < DEB; k++) begin
            sample_valid = 1'b1;
            btn_sample   = 8'h1A;
            cycle();
        end
        chk("held press btn_state", btn_state, 8'h1A);
        chk("held press no event yet", evt_valid, 1'b0);
        sample_valid = 1'b0;
        cycle();
        chk("held press first code", evt_code, 4'h9);
`ifdef NES_EVT_TIMESTAMP_EN
        chk("first stamp after reset", evt_stamp, 16'd3);
`endif
        repeat (3) cycle();
        chk("held press level", fifo_level, 4'd3);

        // Randomized traffic against the model.
        smp = btn_state;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) smp[$urandom_range(0, 7)] ^= 1'b1;
            sample_valid = ($urandom_range(0, 2) != 0);
            btn_sample   = ($urandom_range(0, 15) == 0) ? 8'($urandom) : smp;
            evt_ready    = (c % 400 < 150) ? 1'b0 : ($urandom_range(0, 2) == 0);
            cycle();
            if (c == 1700) begin
                do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
